// File: rtl/riscv_pkg.sv
// Shared RV32 fetch constants, FSM state type and buffer entry type.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// FIFO of {pc, instr} entries between instruction memory and decode.
// Clear wins over a same-cycle push; push and pop together are legal even when full.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  // A pop in the same cycle frees the slot a push into a full buffer needs.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (clear_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !clear_i) mem_q[wrPtr_q] <= entry_i;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// RV32 fetch sequencer: owns the PC, keeps one imem request in flight, buffers words for decode.
// Define FETCH_PERF_CNT_EN to add the perf_fetch / perf_stall counter ports.
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic            idle
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] reqPc_q, reqPc_d;
  logic            reqAccepted;
  logic            bufPush, bufPop, bufFull, bufEmpty;
  logic [CNT_W-1:0] bufCount;
  fetch_entry_t    bufHead, bufEntry;

  // Only FETCH has no request in flight, so !bufFull equals count + outstanding < depth.
  assign imem_req    = (state_q == FETCH) && !bufFull;
  assign imem_addr   = pc_q;
  assign reqAccepted = imem_req && imem_gnt;

  assign dec_valid = !bufEmpty;
  assign dec_instr = bufEmpty ? NOP_INSTR : bufHead.instr;
  assign dec_pc    = bufEmpty ? '0 : bufHead.pc;
  assign bufPop    = dec_valid && dec_ready;
  assign idle      = (state_q != WAIT) && (state_q != FLUSH) && (bufCount == '0);

  assign bufEntry = '{pc: reqPc_q, instr: imem_rdata};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    reqPc_d = reqPc_q;
    bufPush = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (reqAccepted) begin
        pc_d    = pc_q + 32'd4;
        reqPc_d = pc_q;
        state_d = WAIT;
      end
      WAIT:  if (imem_rvalid) begin
        bufPush = 1'b1;
        state_d = FETCH;
      end
      FLUSH: if (imem_rvalid) state_d = FETCH;
      default: state_d = IDLE;
    endcase
    // A redirect keeps any response still owed to us, but marks it for discard.
    if (redirect_valid) begin
      pc_d    = wordAlign(redirect_pc);
      bufPush = 1'b0;
      state_d = (state_d == WAIT || state_d == FLUSH) ? FLUSH : FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      reqPc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      reqPc_q <= reqPc_d;
    end
  end

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_fetch_buf (
    .clk     (clk),
    .reset   (reset),
    .clear_i (redirect_valid),
    .push_i  (bufPush),
    .entry_i (bufEntry),
    .pop_i   (bufPop),
    .head_o  (bufHead),
    .count_o (bufCount),
    .full_o  (bufFull),
    .empty_o (bufEmpty)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfFetch_q, perfStall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perfFetch_q <= '0;
      perfStall_q <= '0;
    end else begin
      if (reqAccepted) perfFetch_q <= perfFetch_q + 32'd1;
      if (dec_ready && !dec_valid) perfStall_q <= perfStall_q + 32'd1;
    end
  end

  assign perf_fetch = perfFetch_q;
  assign perf_stall = perfStall_q;
`endif

endmodule
